// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory port between the sequencer (master) and memory (slave).
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (output mem_req, mem_we, mem_addr_sel, input mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ack);
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode and memory-timeout traps.
// Optional perf counters are built when MC_PERF_CNT_EN is defined.
module mc_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   mem,
    input  logic [31:0] insn,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    // The counter only has to reach TIMEOUT_CYC-1: the trap fires on the increment that would hit the limit.
    localparam int unsigned WW   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam int unsigned TLIM = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [WW-1:0] TLIM_W = TLIM[WW-1:0];

    state_t        r_state, w_next;
    logic [WW-1:0] r_wait;
    logic          r_illegal, r_bus_err;
    logic [6:0]    w_op;
    logic          w_legal, w_tmo;
    logic          w_unused;

    assign w_op     = insn[6:0];
    assign w_unused = ^insn[31:7];
    assign w_tmo    = (TIMEOUT_CYC != 0) && (r_wait == TLIM_W);

    always_comb begin
        case (w_op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: w_legal = 1'b1;
            default:                          w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next           = r_state;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = 2'd0;
        alu_a_sel        = 1'b0;
        alu_b_sel        = 1'b0;
        rf_we            = 1'b0;
        wb_sel           = 2'd0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_a_sel = (w_op == OP_AUIPC) || (w_op == OP_JAL) || (w_op == OP_BR);
                alu_b_sel = (w_op != OP_OP);
                if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                    w_next = S_MEM;
                end else if (w_op == OP_BR) begin
                    pc_we  = 1'b1;
                    pc_sel = {1'b0, br_taken};
                    w_next = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (w_op == OP_STORE);
                if (mem.mem_ack) begin
                    if (w_op == OP_STORE) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                w_next = S_FETCH;
                case (w_op)
                    OP_LOAD:         wb_sel = 2'd1;
                    OP_JAL, OP_JALR: wb_sel = 2'd2;
                    OP_LUI:          wb_sel = 2'd3;
                    default:         wb_sel = 2'd0;
                endcase
                if (w_op == OP_JAL)       pc_sel = 2'd1;
                else if (w_op == OP_JALR) pc_sel = 2'd2;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (mem.mem_req && !mem.mem_ack)
                r_wait <= r_wait + 1'b1;
            if ((r_state == S_DECODE) && !w_legal)
                r_illegal <= 1'b1;
            if (mem.mem_req && !mem.mem_ack && w_tmo)
                r_bus_err <= 1'b1;
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state_o = r_state;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cyc, r_ret;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc <= '0;
            r_ret <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_TRAP)) r_cyc <= r_cyc + 32'd1;
            if (pc_we) r_ret <= r_ret + 32'd1;
        end
    end
    assign cycle_cnt   = r_cyc;
    assign instret_cnt = r_ret;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboarded bench for mc_ctrl: retirement expectations are queued at fetch and checked at pc_we.
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insn = 32'd0;
    logic        br_taken = 1'b0;
    logic        ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  st;
    logic [31:0] cycle_cnt, instret_cnt;

    mc_ctrl_if bus ();

    mc_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .mem(bus.master), .insn(insn), .br_taken(br_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
        .bus_err(bus_err), .state_o(st), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] BEQ  = 32'h00000463;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic       rf_we;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        br_taken = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        smp();
        n_tests++;
        if ({st, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
             alu_b_sel, rf_we, wb_sel, illegal, bus_err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got st=%0d req=%b ir_we=%b pc_we=%b rf_we=%b ill=%b berr=%b want all 0",
                     st, bus.mem_req, ir_we, pc_we, rf_we, illegal, bus_err);
        end
        n_tests++;
        if ({cycle_cnt, instret_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters got cyc=%0d ret=%0d want 0 0", cycle_cnt, instret_cnt);
        end
        do_reset();
        smp();
        n_tests++;
        if ({st, bus.mem_req} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_after_reset got st=%0d req=%b want 0 0", st, bus.mem_req);
        end
        tick();
        smp();
        n_tests++;
        if ({st, bus.mem_req, bus.mem_addr_sel, bus.mem_we} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_to_fetch got st=%0d req=%b asel=%b we=%b want 1 1 0 0",
                     st, bus.mem_req, bus.mem_addr_sel, bus.mem_we);
        end
    endtask

    task automatic test_addi;
        do_reset();
        insn = ADDI;
        tick();
        bus.mem_ack = 1'b1;
        smp();
        n_tests++;
        if ({st, bus.mem_req, ir_we} !== {3'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL addi_fetch got st=%0d req=%b ir_we=%b want 1 1 1", st, bus.mem_req, ir_we);
        end
        q.push_back('{pc_sel: 2'd0, wb_sel: 2'd0, rf_we: 1'b1});
        tick();
        bus.mem_ack = 1'b0;
        smp();
        n_tests++;
        if ({st, ir_we} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_decode got st=%0d ir_we=%b want 2 0", st, ir_we);
        end
        tick();
        smp();
        n_tests++;
        if ({st, alu_a_sel, alu_b_sel, pc_we, rf_we} !== {3'd3, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_exec got st=%0d a=%b b=%b pc_we=%b rf_we=%b want 3 0 1 0 0",
                     st, alu_a_sel, alu_b_sel, pc_we, rf_we);
        end
        tick();
        smp();
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL addi_retire got empty scoreboard want entry");
        end else begin
            e = q.pop_front();
            if ({st, pc_we, pc_sel, wb_sel, rf_we} !== {3'd5, 1'b1, e.pc_sel, e.wb_sel, e.rf_we}) begin
                n_fail++;
                $display("FAIL addi_retire got st=%0d pc_we=%b pc_sel=%0d wb_sel=%0d rf_we=%b want 5 1 %0d %0d %b",
                         st, pc_we, pc_sel, wb_sel, rf_we, e.pc_sel, e.wb_sel, e.rf_we);
            end
        end
        tick();
        smp();
        n_tests++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL addi_next_fetch got st=%0d want 1", st);
        end
    endtask

    task automatic test_load_store;
        // LW with three wait cycles; the ack lands exactly on the timeout boundary and must win.
        do_reset();
        insn = LW;
        tick();
        bus.mem_ack = 1'b1;
        smp();
        q.push_back('{pc_sel: 2'd0, wb_sel: 2'd1, rf_we: 1'b1});
        tick();
        bus.mem_ack = 1'b0;
        tick();
        smp();
        n_tests++;
        if ({st, alu_a_sel, alu_b_sel} !== {3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL lw_exec got st=%0d a=%b b=%b want 3 0 1", st, alu_a_sel, alu_b_sel);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            smp();
            n_tests++;
            if ({st, bus.mem_req, bus.mem_addr_sel, bus.mem_we, pc_we} !== {3'd4, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL lw_mem_wait%0d got st=%0d req=%b asel=%b we=%b pc_we=%b want 4 1 1 0 0",
                         i, st, bus.mem_req, bus.mem_addr_sel, bus.mem_we, pc_we);
            end
        end
        tick();
        bus.mem_ack = 1'b1;
        smp();
        tick();
        bus.mem_ack = 1'b0;
        smp();
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL lw_retire got empty scoreboard want entry");
        end else begin
            e = q.pop_front();
            if ({st, pc_we, pc_sel, wb_sel, rf_we, bus_err} !== {3'd5, 1'b1, e.pc_sel, e.wb_sel, e.rf_we, 1'b0}) begin
                n_fail++;
                $display("FAIL lw_retire got st=%0d pc_we=%b pc_sel=%0d wb_sel=%0d rf_we=%b berr=%b want 5 1 %0d %0d %b 0",
                         st, pc_we, pc_sel, wb_sel, rf_we, bus_err, e.pc_sel, e.wb_sel, e.rf_we);
            end
        end
        // SW with zero wait: retires in MEM, four cycles from fetch ack to next fetch.
        do_reset();
        insn = SW;
        tick();
        bus.mem_ack = 1'b1;
        smp();
        q.push_back('{pc_sel: 2'd0, wb_sel: 2'd0, rf_we: 1'b0});
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
        bus.mem_ack = 1'b1;
        smp();
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sw_retire got empty scoreboard want entry");
        end else begin
            e = q.pop_front();
            if ({st, bus.mem_we, bus.mem_addr_sel, pc_we, pc_sel, wb_sel, rf_we} !==
                {3'd4, 1'b1, 1'b1, 1'b1, e.pc_sel, e.wb_sel, e.rf_we}) begin
                n_fail++;
                $display("FAIL sw_retire got st=%0d we=%b asel=%b pc_we=%b pc_sel=%0d rf_we=%b want 4 1 1 1 %0d %b",
                         st, bus.mem_we, bus.mem_addr_sel, pc_we, pc_sel, rf_we, e.pc_sel, e.rf_we);
            end
        end
        tick();
        bus.mem_ack = 1'b0;
        smp();
        n_tests++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL sw_next_fetch got st=%0d want 1", st);
        end
    endtask

    task automatic test_branch;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            insn = BEQ;
            tick();
            bus.mem_ack = 1'b1;
            smp();
            q.push_back('{pc_sel: (t == 0) ? 2'd1 : 2'd0, wb_sel: 2'd0, rf_we: 1'b0});
            tick();
            bus.mem_ack = 1'b0;
            tick();
            br_taken = (t == 0);
            smp();
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL beq_retire%0d got empty scoreboard want entry", t);
            end else begin
                e = q.pop_front();
                if ({st, alu_a_sel, alu_b_sel, pc_we, pc_sel, wb_sel, rf_we} !==
                    {3'd3, 1'b1, 1'b1, 1'b1, e.pc_sel, e.wb_sel, e.rf_we}) begin
                    n_fail++;
                    $display("FAIL beq_retire%0d got st=%0d a=%b b=%b pc_we=%b pc_sel=%0d rf_we=%b want 3 1 1 1 %0d %b",
                             t, st, alu_a_sel, alu_b_sel, pc_we, pc_sel, rf_we, e.pc_sel, e.rf_we);
                end
            end
            tick();
            br_taken = 1'b0;
            smp();
            n_tests++;
            if ({st, rf_we} !== {3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL beq_next_fetch%0d got st=%0d rf_we=%b want 1 0", t, st, rf_we);
            end
        end
    endtask

    task automatic test_jumps;
        logic [31:0] ti [5] = '{32'h010000EF, 32'h000080E7, 32'h123450B7, 32'h00001097, 32'h002081B3};
        logic        ea [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  ew [5] = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
        logic [1:0]  ep [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            insn = ti[k];
            tick();
            bus.mem_ack = 1'b1;
            smp();
            q.push_back('{pc_sel: ep[k], wb_sel: ew[k], rf_we: 1'b1});
            tick();
            bus.mem_ack = 1'b0;
            tick();
            smp();
            n_tests++;
            if ({st, alu_a_sel, alu_b_sel, pc_we} !== {3'd3, ea[k], eb[k], 1'b0}) begin
                n_fail++;
                $display("FAIL jump_exec insn=%h got st=%0d a=%b b=%b pc_we=%b want 3 %b %b 0",
                         ti[k], st, alu_a_sel, alu_b_sel, pc_we, ea[k], eb[k]);
            end
            tick();
            smp();
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL jump_retire insn=%h got empty scoreboard want entry", ti[k]);
            end else begin
                e = q.pop_front();
                if ({st, pc_we, pc_sel, wb_sel, rf_we} !== {3'd5, 1'b1, e.pc_sel, e.wb_sel, e.rf_we}) begin
                    n_fail++;
                    $display("FAIL jump_retire insn=%h got st=%0d pc_we=%b pc_sel=%0d wb_sel=%0d rf_we=%b want 5 1 %0d %0d %b",
                             ti[k], st, pc_we, pc_sel, wb_sel, rf_we, e.pc_sel, e.wb_sel, e.rf_we);
                end
            end
        end
    endtask

    task automatic test_illegal;
        do_reset();
        insn = 32'h00000000;
        tick();
        bus.mem_ack = 1'b1;
        smp();
        tick();
        bus.mem_ack = 1'b0;
        smp();
        n_tests++;
        if ({st, illegal} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL ill_decode got st=%0d ill=%b want 2 0", st, illegal);
        end
        tick();
        smp();
        n_tests++;
        if ({st, illegal, bus_err, bus.mem_req} !== {3'd7, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ill_trap got st=%0d ill=%b berr=%b req=%b want 7 1 0 0", st, illegal, bus_err, bus.mem_req);
        end
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            smp();
            n_tests++;
            if ({st, ir_we, bus.mem_req, pc_we, rf_we, illegal} !== {3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL ill_hold%0d got st=%0d ir_we=%b req=%b pc_we=%b ill=%b want 7 0 0 0 1",
                         i, st, ir_we, bus.mem_req, pc_we, illegal);
            end
        end
        do_reset();
        smp();
        n_tests++;
        if ({st, illegal} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ill_cleared got st=%0d ill=%b want 0 0", st, illegal);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        insn = ADDI;
        tick();
        for (int i = 0; i < 4; i++) begin
            smp();
            n_tests++;
            if ({st, bus.mem_req, bus_err} !== {3'd1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL tmo_fetch_wait%0d got st=%0d req=%b berr=%b want 1 1 0", i, st, bus.mem_req, bus_err);
            end
            tick();
        end
        smp();
        n_tests++;
        if ({st, bus_err, bus.mem_req, illegal} !== {3'd7, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_fetch_trap got st=%0d berr=%b req=%b ill=%b want 7 1 0 0", st, bus_err, bus.mem_req, illegal);
        end
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) tick();
        bus.mem_ack = 1'b1;
        smp();
        n_tests++;
        if ({st, ir_we} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_ack_edge got st=%0d ir_we=%b want 1 1", st, ir_we);
        end
        tick();
        bus.mem_ack = 1'b0;
        smp();
        n_tests++;
        if ({st, bus_err} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_ack_wins got st=%0d berr=%b want 2 0", st, bus_err);
        end
        // Store that never gets its data ack.
        do_reset();
        insn = SW;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) tick();
        smp();
        n_tests++;
        if ({st, bus_err, bus.mem_req, bus.mem_we, pc_we} !== {3'd7, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_mem_trap got st=%0d berr=%b req=%b we=%b pc_we=%b want 7 1 0 0 0",
                     st, bus_err, bus.mem_req, bus.mem_we, pc_we);
        end
        // Reset in the middle of a load access.
        do_reset();
        insn = LW;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
        smp();
        n_tests++;
        if ({st, bus.mem_req} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_mem_pre got st=%0d req=%b want 4 1", st, bus.mem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({st, bus.mem_req, bus.mem_addr_sel} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_mem got st=%0d req=%b asel=%b want 0 0 0", st, bus.mem_req, bus.mem_addr_sel);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        insn = ADDI;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.mem_ack = 1'b1;
            smp();
            q.push_back('{pc_sel: 2'd0, wb_sel: 2'd0, rf_we: 1'b1});
            tick();
            bus.mem_ack = 1'b0;
            tick();
            tick();
            smp();
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_retire%0d got empty scoreboard want entry", k);
            end else begin
                e = q.pop_front();
                if ({st, pc_we, pc_sel, wb_sel, rf_we} !== {3'd5, 1'b1, e.pc_sel, e.wb_sel, e.rf_we}) begin
                    n_fail++;
                    $display("FAIL b2b_retire%0d got st=%0d pc_we=%b pc_sel=%0d wb_sel=%0d rf_we=%b want 5 1 %0d %0d %b",
                             k, st, pc_we, pc_sel, wb_sel, rf_we, e.pc_sel, e.wb_sel, e.rf_we);
                end
            end
            tick();
        end
        smp();
        n_tests++;
`ifdef MC_PERF_CNT_EN
        if ({st, instret_cnt, cycle_cnt} !== {3'd1, 32'd3, 32'd12}) begin
            n_fail++;
            $display("FAIL b2b_perf got st=%0d ret=%0d cyc=%0d want 1 3 12", st, instret_cnt, cycle_cnt);
        end
`else
        if ({st, instret_cnt, cycle_cnt} !== {3'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_perf got st=%0d ret=%0d cyc=%0d want 1 0 0", st, instret_cnt, cycle_cnt);
        end
`endif
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_timeout();
        test_back_to_back();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle sequencer for the RV32I core datapath: register file, ALU, immediate sign-extender, PC and a shared instruction/data memory port. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives mux selects and write enables from the IR opcode, arbitrates the single memory port between fetch and load/store, and traps on illegal opcodes and memory timeouts.

Parameters:
TIMEOUT_CYC, 255, maximum cycles mem_req may stay high without mem_ack before bus error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
insn  in  32  current IR contents; only insn[6:0] is decoded
br_taken  in  1  branch comparator result, valid in EXEC
mem_ack  in  1  memory access complete, single-cycle pulse
mem_req  out  1  memory access request, held until ack
mem_we  out  1  1 = store write
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_sel  out  2  0 = PC+4, 1 = ALU target (JAL/branch), 2 = JALR target with bit0 cleared
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm_x
rf_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm_x
illegal  out  1  sticky: illegal opcode trapped
bus_err  out  1  sticky: memory timeout trapped
state_o  out  3  current state, for debug
cycle_cnt  out  32  cycle counter (optional feature)
instret_cnt  out  32  retired-instruction counter (optional feature)

Behaviour:
- Reset (async, rst=1): state=IDLE(0), all outputs 0, wait counter 0, illegal=0, bus_err=0. Asserting rst mid-access drops mem_req immediately and abandons the access.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Outputs are combinational from state, insn, mem_ack and br_taken.
- IDLE: all outputs 0; goes to FETCH on the next cycle.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ack=1, ir_we=1 in the same cycle and the next state is DECODE. Otherwise the state holds.
- DECODE: one cycle. Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP. Legal goes to EXEC; any other opcode goes to TRAP with illegal set.
- EXEC, ALU selects:
  - AUIPC, JAL, BRANCH: a=PC, b=imm.
  - OP: a=rs1, b=rs2.
  - All others: a=rs1, b=imm.
- EXEC, next state:
  - LOAD or STORE: MEM.
  - BRANCH: pc_we=1, pc_sel=br_taken?1:0, then FETCH. No WB.
  - Others: WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. Waits for mem_ack. On ack, LOAD goes to WB; STORE asserts pc_we=1, pc_sel=0 and goes to FETCH.
- WB: rf_we=1; the regfile discards x0 writes.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, others=0.
  - pc_we=1; pc_sel: JAL=1, JALR=2, others=0.
  - Next state FETCH.
- Retirement: an instruction retires on the cycle pc_we=1.
- Zero-wait latency, from the cycle the FETCH ack arrives to the next FETCH:
  - BRANCH: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYC (TIMEOUT_CYC≠0), the next state is TRAP, bus_err is set and mem_req drops.
  - If mem_ack arrives in the same cycle as the limit, the ack wins and no error is raised.
- mem_ack outside FETCH/MEM is ignored.
- TRAP: all enables 0, mem_req=0; held until reset.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle the state is not IDLE or TRAP.
  - instret_cnt increments on every pc_we=1 cycle.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- ADDI 0x00500093, mem_ack every request cycle → states 0,1,2,3,5,1. EXEC: alu_b_sel=1. WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
- LW 0x0000A103 with a 3-cycle MEM wait → mem_addr_sel=1, mem_we=0 for 3 cycles; then WB with wb_sel=1. STORE 0x0020A223 → mem_we=1, no rf_we, pc_sel=0.
- BEQ 0x00000463: br_taken=1 gives EXEC pc_we=1, pc_sel=1; br_taken=0 gives pc_sel=0. In both cases rf_we never asserts.
- JAL 0x010000EF → EXEC alu_a_sel=1. WB: wb_sel=2, pc_sel=1. JALR 0x000080E7 → WB pc_sel=2. LUI 0x123450B7 → wb_sel=3.
- insn 0x00000000 → DECODE then TRAP; illegal=1, state_o=7; stays in TRAP despite mem_ack until rst.
- TIMEOUT_CYC=4, no ack in FETCH → TRAP after 4 request cycles, bus_err=1. Ack on the 4th cycle → normal DECODE. rst pulsed mid-MEM → mem_req=0 immediately. With MC_PERF_CNT_EN, after 3 ADDIs instret_cnt=3.
